n1_ir_stack: RTL and testbench

- Next-generation N1 instruction register.
- Replaces the single stash slot with a parametrised LIFO of stashed opcodes.
- Generalises opcode width and force-instruction encodings; adds stash level, full/empty status and sticky overflow/underflow errors.
- Sits between the program bus read data and the FC/PAGU/PRS decode logic. Owns the current IR and the stashed IRs; performs no opcode decode beyond the EOW bit.

---
 rtl/n1_ir_stack_if.sv | 50 +++++
 rtl/n1_ir_stack.sv | 120 ++++++++++++
 tb/tb_n1_ir_stack.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/n1_ir_stack_if.sv
// N1 instruction-register stack bus.
// Bundles the program-bus read data and the FC control strobes (driven by
// the FC side) with the IR/stash status returned by the IR stack.
//   master : FC side, drives pbus_dat_i and fc2ir_*, observes the status
//   slave  : IR stack, consumes the strobes, drives ir_o / stash_* / err_*
interface n1_ir_stack_if #(
  parameter int IR_WIDTH    = 16,
  parameter int STASH_DEPTH = 4
);
  localparam int LVL_W = $clog2(STASH_DEPTH + 1);

  logic [IR_WIDTH-1:0] pbus_dat_i;
  logic                fc2ir_capture_i;
  logic                fc2ir_stash_i;
  logic                fc2ir_expend_i;
  logic                fc2ir_force_eow_i;
  logic                fc2ir_force_0call_i;
  logic                fc2ir_force_call_i;
  logic                fc2ir_force_drop_i;
  logic                fc2ir_force_nop_i;
  logic                fc2ir_flush_i;
  logic                fc2ir_err_clr_i;

  logic [IR_WIDTH-1:0] ir_o;
  logic                ir_eow_o;
  logic [IR_WIDTH-1:0] stash_top_o;
  logic [LVL_W-1:0]    stash_lvl_o;
  logic                stash_empty_o;
  logic                stash_full_o;
  logic                err_ovf_o;
  logic                err_udf_o;

  modport master (
    output pbus_dat_i, fc2ir_capture_i, fc2ir_stash_i, fc2ir_expend_i,
           fc2ir_force_eow_i, fc2ir_force_0call_i, fc2ir_force_call_i,
           fc2ir_force_drop_i, fc2ir_force_nop_i, fc2ir_flush_i,
           fc2ir_err_clr_i,
    input  ir_o, ir_eow_o, stash_top_o, stash_lvl_o, stash_empty_o,
           stash_full_o, err_ovf_o, err_udf_o
  );

  modport slave (
    input  pbus_dat_i, fc2ir_capture_i, fc2ir_stash_i, fc2ir_expend_i,
           fc2ir_force_eow_i, fc2ir_force_0call_i, fc2ir_force_call_i,
           fc2ir_force_drop_i, fc2ir_force_nop_i, fc2ir_flush_i,
           fc2ir_err_clr_i,
    output ir_o, ir_eow_o, stash_top_o, stash_lvl_o, stash_empty_o,
           stash_full_o, err_ovf_o, err_udf_o
  );
endinterface

// File: rtl/n1_ir_stack.sv
// N1 instruction register with a LIFO of stashed opcodes.
// Holds the current IR and up to STASH_DEPTH stashed opcodes; the only
// decode performed is the EOW flag. Sticky overflow/underflow flags record
// pushes while full and pops while empty.
//   clk_i      : clock, all state changes on the rising edge
//   sync_rst_i : synchronous reset, active high (stash storage not reset)
//   ir_bus     : n1_ir_stack_if.slave - program data, FC strobes, status
module n1_ir_stack #(
  parameter int                  IR_WIDTH    = 16,
  parameter int                  STASH_DEPTH = 4,
  parameter int                  EOW_BIT     = 15,
  parameter logic [IR_WIDTH-1:0] NOP_OPC     = 16'h8000,
  parameter logic [IR_WIDTH-1:0] DROP_OPC    = 16'h8400,
  parameter logic [IR_WIDTH-1:0] CALL_OPC    = 16'h4000,
  parameter logic [IR_WIDTH-1:0] ADR_MASK    = 16'h3FFF
) (
  input logic          clk_i,
  input logic          sync_rst_i,
  n1_ir_stack_if.slave ir_bus
);
  localparam int LVL_W = $clog2(STASH_DEPTH + 1);
  localparam int IDX_W = $clog2(STASH_DEPTH);

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [IR_WIDTH-1:0] mem_q [STASH_DEPTH];

  logic                empty, full;
  logic [IDX_W-1:0]    top_idx;
  logic [IR_WIDTH-1:0] top_val;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;

  logic stash, expend, flush;

  assign stash  = ir_bus.fc2ir_stash_i;
  assign expend = ir_bus.fc2ir_expend_i;
  assign flush  = ir_bus.fc2ir_flush_i;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(STASH_DEPTH));
  // Only meaningful when not empty; top_val masks the empty case to zero.
  assign top_idx = IDX_W'(level_q - LVL_W'(1));
  assign top_val = empty ? '0 : mem_q[top_idx];

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ir_d    = ir_q;
    level_d = level_q;
    mem_we  = 1'b0;
    mem_idx = IDX_W'(level_q);

    // IR selection in priority order; a flushed or empty expend yields NOP.
    if (ir_bus.fc2ir_force_nop_i)        ir_d = NOP_OPC;
    else if (ir_bus.fc2ir_force_drop_i)  ir_d = DROP_OPC;
    else if (ir_bus.fc2ir_force_0call_i) ir_d = CALL_OPC;
    else if (ir_bus.fc2ir_force_call_i)  ir_d = CALL_OPC | (ir_bus.pbus_dat_i & ADR_MASK);
    else if (expend)                     ir_d = (flush || empty) ? NOP_OPC : top_val;
    else if (ir_bus.fc2ir_capture_i)     ir_d = ir_bus.pbus_dat_i;
    if (ir_bus.fc2ir_force_eow_i)        ir_d[EOW_BIT] = 1'b1;

    // Stash pointer/storage; a masked expend still pops.
    if (flush) begin
      level_d = '0;
    end else if (stash && expend) begin
      mem_we = 1'b1;
      if (empty) begin
        mem_idx = '0;
        level_d = LVL_W'(1);
      end else begin
        mem_idx = top_idx;
      end
    end else if (stash) begin
      if (!full) begin
        mem_we  = 1'b1;
        level_d = level_q + LVL_W'(1);
      end
    end else if (expend && !empty) begin
      level_d = level_q - LVL_W'(1);
    end

    // A fresh error in the clear cycle wins over the clear.
    ovf_d = (ovf_q & ~ir_bus.fc2ir_err_clr_i) | (stash & full & ~expend & ~flush);
    udf_d = (udf_q & ~ir_bus.fc2ir_err_clr_i) | (expend & empty & ~flush);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      ir_q    <= NOP_OPC;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: stash storage has no reset; the level counter alone defines which
  // entries are valid, so clearing the array would only cost reset fanout.
  always_ff @(posedge clk_i) begin
    if (mem_we && !sync_rst_i) mem_q[mem_idx] <= ir_bus.pbus_dat_i;
  end

  assign ir_bus.ir_o          = ir_q;
  assign ir_bus.ir_eow_o      = ir_q[EOW_BIT];
  assign ir_bus.stash_top_o   = top_val;
  assign ir_bus.stash_lvl_o   = level_q;
  assign ir_bus.stash_empty_o = empty;
  assign ir_bus.stash_full_o  = full;
  assign ir_bus.err_ovf_o     = ovf_q;
  assign ir_bus.err_udf_o     = udf_q;
endmodule

// File: tb/tb_n1_ir_stack.sv
// Self-checking bench for n1_ir_stack: a table of per-cycle stimulus with
// expected post-edge outputs; expectations are queued when stimulus is
// driven and popped and compared once the clock edge has produced output.
module tb_n1_ir_stack;
  localparam int C_RST   = 0;
  localparam int C_CAP   = 1;
  localparam int C_STASH = 2;
  localparam int C_EXP   = 3;
  localparam int C_EOW   = 4;
  localparam int C_F0C   = 5;
  localparam int C_FCALL = 6;
  localparam int C_FDROP = 7;
  localparam int C_FNOP  = 8;
  localparam int C_FLUSH = 9;
  localparam int C_CLR   = 10;

  localparam logic [10:0] RST   = 11'(1 << C_RST);
  localparam logic [10:0] CAP   = 11'(1 << C_CAP);
  localparam logic [10:0] STASH = 11'(1 << C_STASH);
  localparam logic [10:0] EXP   = 11'(1 << C_EXP);
  localparam logic [10:0] EOW   = 11'(1 << C_EOW);
  localparam logic [10:0] F0C   = 11'(1 << C_F0C);
  localparam logic [10:0] FCALL = 11'(1 << C_FCALL);
  localparam logic [10:0] FDROP = 11'(1 << C_FDROP);
  localparam logic [10:0] FNOP  = 11'(1 << C_FNOP);
  localparam logic [10:0] FLUSH = 11'(1 << C_FLUSH);
  localparam logic [10:0] CLR   = 11'(1 << C_CLR);
  localparam logic [10:0] IDLE  = 11'd0;

  typedef struct {
    logic [10:0] ctrl;
    logic [15:0] dat;
    logic [15:0] ir;
    int          lvl;
    logic [15:0] top;
    bit          ovf;
    bit          udf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t sb[$];

  n1_ir_stack_if #(.IR_WIDTH(16), .STASH_DEPTH(4)) bus ();

  n1_ir_stack dut (
    .clk_i      (clk),
    .sync_rst_i (rst),
    .ir_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(logic [10:0] c, logic [15:0] d, logic [15:0] ir,
                               int lvl, logic [15:0] top, bit ovf, bit udf);
    vec_t v;
    v.ctrl = c; v.dat = d; v.ir = ir; v.lvl = lvl; v.top = top;
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                     = v.ctrl[C_RST];
    bus.pbus_dat_i          = v.dat;
    bus.fc2ir_capture_i     = v.ctrl[C_CAP];
    bus.fc2ir_stash_i       = v.ctrl[C_STASH];
    bus.fc2ir_expend_i      = v.ctrl[C_EXP];
    bus.fc2ir_force_eow_i   = v.ctrl[C_EOW];
    bus.fc2ir_force_0call_i = v.ctrl[C_F0C];
    bus.fc2ir_force_call_i  = v.ctrl[C_FCALL];
    bus.fc2ir_force_drop_i  = v.ctrl[C_FDROP];
    bus.fc2ir_force_nop_i   = v.ctrl[C_FNOP];
    bus.fc2ir_flush_i       = v.ctrl[C_FLUSH];
    bus.fc2ir_err_clr_i     = v.ctrl[C_CLR];
  endtask

  task automatic compare(input int idx, input vec_t e);
    check($sformatf("v%0d ir", idx),    32'(bus.ir_o),          32'(e.ir));
    check($sformatf("v%0d eow", idx),   32'(bus.ir_eow_o),      32'(e.ir[15]));
    check($sformatf("v%0d lvl", idx),   32'(bus.stash_lvl_o),   32'(e.lvl));
    check($sformatf("v%0d top", idx),   32'(bus.stash_top_o),   32'(e.top));
    check($sformatf("v%0d empty", idx), 32'(bus.stash_empty_o), 32'(e.lvl == 0));
    check($sformatf("v%0d full", idx),  32'(bus.stash_full_o),  32'(e.lvl == 4));
    check($sformatf("v%0d ovf", idx),   32'(bus.err_ovf_o),     32'(e.ovf));
    check($sformatf("v%0d udf", idx),   32'(bus.err_udf_o),     32'(e.udf));
  endtask

  initial begin
    //                 ctrl                 dat       ir        lvl top       ovf udf
    // Reset and idle
    vecs.push_back(mkv(RST,                 16'h0000, 16'h8000, 0, 16'h0000, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(IDLE,              16'h5555, 16'h8000, 0, 16'h0000, 0, 0));
    // Capture, capture with forced EOW
    vecs.push_back(mkv(CAP,                 16'h1234, 16'h1234, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(CAP | EOW,           16'h0042, 16'h8042, 0, 16'h0000, 0, 0));
    // Fill the stash, overflow, drain
    vecs.push_back(mkv(STASH,               16'hA001, 16'h8042, 1, 16'hA001, 0, 0));
    vecs.push_back(mkv(STASH,               16'hA002, 16'h8042, 2, 16'hA002, 0, 0));
    vecs.push_back(mkv(STASH,               16'hA003, 16'h8042, 3, 16'hA003, 0, 0));
    vecs.push_back(mkv(STASH,               16'hA004, 16'h8042, 4, 16'hA004, 0, 0));
    vecs.push_back(mkv(STASH,               16'hA005, 16'h8042, 4, 16'hA004, 1, 0));
    vecs.push_back(mkv(EXP,                 16'h0000, 16'hA004, 3, 16'hA003, 1, 0));
    vecs.push_back(mkv(EXP,                 16'h0000, 16'hA003, 2, 16'hA002, 1, 0));
    vecs.push_back(mkv(EXP,                 16'h0000, 16'hA002, 1, 16'hA001, 1, 0));
    vecs.push_back(mkv(EXP,                 16'h0000, 16'hA001, 0, 16'h0000, 1, 0));
    // Underflow with EOW, then clear
    vecs.push_back(mkv(EXP | EOW,           16'h0000, 16'h8000, 0, 16'h0000, 1, 1));
    vecs.push_back(mkv(CLR,                 16'h0000, 16'h8000, 0, 16'h0000, 0, 0));
    // Simultaneous stash + expend at level 2
    vecs.push_back(mkv(STASH,               16'hB001, 16'h8000, 1, 16'hB001, 0, 0));
    vecs.push_back(mkv(STASH,               16'hB002, 16'h8000, 2, 16'hB002, 0, 0));
    vecs.push_back(mkv(STASH | EXP,         16'hC000, 16'hB002, 2, 16'hC000, 0, 0));
    vecs.push_back(mkv(EXP,                 16'h0000, 16'hC000, 1, 16'hB001, 0, 0));
    // force_call masks an expend that still pops
    vecs.push_back(mkv(FCALL | EXP,         16'hFFFF, 16'h7FFF, 0, 16'h0000, 0, 0));
    // Reset in the middle of stashing at level 3
    vecs.push_back(mkv(STASH,               16'hD001, 16'h7FFF, 1, 16'hD001, 0, 0));
    vecs.push_back(mkv(STASH,               16'hD002, 16'h7FFF, 2, 16'hD002, 0, 0));
    vecs.push_back(mkv(STASH,               16'hD003, 16'h7FFF, 3, 16'hD003, 0, 0));
    vecs.push_back(mkv(RST | STASH | CAP,   16'hD004, 16'h8000, 0, 16'h0000, 0, 0));
    // Flush beats stash/expend; expend under flush gives NOP, no error
    vecs.push_back(mkv(STASH,               16'hE001, 16'h8000, 1, 16'hE001, 0, 0));
    vecs.push_back(mkv(STASH,               16'hE002, 16'h8000, 2, 16'hE002, 0, 0));
    vecs.push_back(mkv(CAP,                 16'h0777, 16'h0777, 2, 16'hE002, 0, 0));
    vecs.push_back(mkv(FLUSH | EXP | STASH, 16'hE003, 16'h8000, 0, 16'h0000, 0, 0));
    // Stash + expend on empty: underflow, push still lands
    vecs.push_back(mkv(STASH | EXP,         16'hF00F, 16'h8000, 1, 16'hF00F, 0, 1));
    vecs.push_back(mkv(CLR | EXP,           16'h0000, 16'hF00F, 0, 16'h0000, 0, 0));
    // Clear and new underflow together: new error wins
    vecs.push_back(mkv(CLR | EXP,           16'h0000, 16'h8000, 0, 16'h0000, 0, 1));
    vecs.push_back(mkv(CLR,                 16'h0000, 16'h8000, 0, 16'h0000, 0, 0));
    // Force priorities and EOW on hold
    vecs.push_back(mkv(FDROP | CAP | EOW,   16'h1111, 16'h8400, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(CAP,                 16'h0123, 16'h0123, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(EOW,                 16'h0000, 16'h8123, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(FNOP | FDROP | F0C,  16'h0000, 16'h8000, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(F0C | FCALL | CAP,   16'h3FFF, 16'h4000, 0, 16'h0000, 0, 0));
    vecs.push_back(mkv(FCALL,               16'hC123, 16'h4123, 0, 16'h0000, 0, 0));
    // Stash + expend while full is legal; overflow set alongside clear
    vecs.push_back(mkv(STASH,               16'h0001, 16'h4123, 1, 16'h0001, 0, 0));
    vecs.push_back(mkv(STASH,               16'h0002, 16'h4123, 2, 16'h0002, 0, 0));
    vecs.push_back(mkv(STASH,               16'h0003, 16'h4123, 3, 16'h0003, 0, 0));
    vecs.push_back(mkv(STASH,               16'h0004, 16'h4123, 4, 16'h0004, 0, 0));
    vecs.push_back(mkv(STASH | EXP,         16'h0005, 16'h0004, 4, 16'h0005, 0, 0));
    vecs.push_back(mkv(STASH | CLR,         16'h0006, 16'h0004, 4, 16'h0005, 1, 0));
    vecs.push_back(mkv(FDROP | EXP,         16'h0000, 16'h8400, 3, 16'h0003, 1, 0));
    vecs.push_back(mkv(FLUSH,               16'h0000, 16'h8400, 0, 16'h0000, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
      end else begin
        compare(i, sb.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
